bin_downscale: RTL and testbench

BIN_DOWNSCALE -- requirements
Module: bin_downscale

---
 rtl/bin_downscale_pkg.sv | 16 +
 rtl/bin_downscale_linebuf.sv | 22 ++
 rtl/bin_downscale.sv | 129 ++++++++++++
 tb/tb_bin_downscale.sv | 197 +++++++++++++++++++
 4 files changed

// File: rtl/bin_downscale_pkg.sv
// Shared constants for the binarizing 2x2 downscaler and the ROI capture stage
// downstream of it.
package bin_downscale_pkg;
  localparam int DEF_IN_W    = 640;
  localparam int DEF_IN_H    = 480;
  localparam int DEF_OUT_W   = DEF_IN_W / 2;
  localparam int DEF_OUT_H   = DEF_IN_H / 2;
  localparam int PIX_W       = 8;
  localparam int PAIR_W      = 9;
  localparam int BLOCK_SUM_W = 10;

  typedef enum logic {
    ST_IDLE   = 1'b0,
    ST_ACTIVE = 1'b1
  } frame_state_e;
endpackage

// File: rtl/bin_downscale_linebuf.sv
// bin_linebuf: single-clock simple dual-port line memory, one write port and one
// read port with a registered read; contents are never reset.
module bin_linebuf #(
  parameter int DEPTH = 320,
  parameter int W     = 9,
  parameter int AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic          clk,
  input  logic          wr_en,
  input  logic [AW-1:0] wr_addr,
  input  logic [W-1:0]  wr_data,
  input  logic          rd_en,
  input  logic [AW-1:0] rd_addr,
  output logic [W-1:0]  rd_data
);
  logic [W-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_addr] <= wr_data;
    if (rd_en) rd_data <= mem[rd_addr];
  end
endmodule

// File: rtl/bin_downscale.sv
// Reduces each 2x2 grayscale block to one thresholded binary pixel, streaming
// in raster order. Define BIN_DOWNSCALE_INVERT_EN for dark-object polarity.
module bin_downscale
  import bin_downscale_pkg::*;
#(
  parameter int IN_W = DEF_IN_W,
  parameter int IN_H = DEF_IN_H
) (
  input  logic             iCLK,
  input  logic             iRST,
  input  logic [PIX_W-1:0] iDATA,
  input  logic             iDVAL,
  input  logic             iFVAL,
  input  logic [7:0]       iThreshold,
  output logic             oDATA,
  output logic             oDVAL,
  output logic             oFrameStart,
  output logic [8:0]       oX,
  output logic [7:0]       oY
);
  localparam int CW = $clog2(IN_W);
  localparam int LW = $clog2(IN_H);

  frame_state_e            state_q, state_d;
  logic                    fval_prev;
  logic [CW-1:0]           col_q, col_d, col_cur;
  logic [LW-1:0]           line_q, line_d, line_cur;
  logic [7:0]              thr_q;
  logic [PIX_W-1:0]        pix_q;
  logic                    rise, accept, odd_col, odd_line;
  logic [PAIR_W-1:0]       pair_sum, buf_rd;
  logic [BLOCK_SUM_W-1:0]  block_sum, thr_cmp;
  logic                    hit;

  // A rising iFVAL restarts the frame in the same cycle, so the pixel that
  // arrives with it is column 0 of line 0.
  assign rise     = iFVAL & ~fval_prev;
  assign col_cur  = rise ? '0 : col_q;
  assign line_cur = rise ? '0 : line_q;
  assign accept   = iFVAL & iDVAL & (rise | (state_q == ST_ACTIVE));
  assign odd_col  = col_cur[0];
  assign odd_line = line_cur[0];

  always_comb begin
    state_d = state_q;
    col_d   = col_q;
    line_d  = line_q;
    if (!iFVAL) begin
      state_d = ST_IDLE;
      col_d   = '0;
      line_d  = '0;
    end else begin
      if (rise) begin
        state_d = ST_ACTIVE;
        col_d   = '0;
        line_d  = '0;
      end
      if (accept) begin
        if (col_cur == CW'(IN_W - 1)) begin
          col_d = '0;
          if (line_cur == LW'(IN_H - 1)) begin
            line_d  = '0;
            state_d = ST_IDLE;
          end else begin
            line_d = line_cur + LW'(1);
          end
        end else begin
          col_d = col_cur + CW'(1);
        end
      end
    end
  end

  assign pair_sum  = PAIR_W'(pix_q) + PAIR_W'(iDATA);
  assign block_sum = BLOCK_SUM_W'(buf_rd) + BLOCK_SUM_W'(pair_sum);
  assign thr_cmp   = {thr_q, 2'b00};
`ifdef BIN_DOWNSCALE_INVERT_EN
  assign hit = (block_sum < thr_cmp);
`else
  assign hit = (block_sum >= thr_cmp);
`endif

  // Even lines store pair sums; odd lines fetch them on the even pixel so the
  // registered read is ready when the odd pixel arrives.
  bin_linebuf #(
    .DEPTH (IN_W / 2),
    .W     (PAIR_W)
  ) u_linebuf (
    .clk     (iCLK),
    .wr_en   (accept & odd_col & ~odd_line),
    .wr_addr (col_cur[CW-1:1]),
    .wr_data (pair_sum),
    .rd_en   (accept & ~odd_col & odd_line),
    .rd_addr (col_cur[CW-1:1]),
    .rd_data (buf_rd)
  );

  // fval_prev resets high so a frame already in flight at reset release is
  // not mistaken for a new one.
  always_ff @(posedge iCLK or negedge iRST) begin
    if (!iRST) begin
      state_q     <= ST_IDLE;
      fval_prev   <= 1'b1;
      col_q       <= '0;
      line_q      <= '0;
      thr_q       <= '0;
      pix_q       <= '0;
      oDATA       <= 1'b0;
      oDVAL       <= 1'b0;
      oFrameStart <= 1'b0;
      oX          <= '0;
      oY          <= '0;
    end else begin
      state_q     <= state_d;
      fval_prev   <= iFVAL;
      col_q       <= col_d;
      line_q      <= line_d;
      oFrameStart <= rise;
      oDVAL       <= accept & odd_col & odd_line;
      if (rise) thr_q <= iThreshold;
      if (accept & ~odd_col) pix_q <= iDATA;
      if (accept & odd_col & odd_line) begin
        oDATA <= hit;
        oX    <= 9'(col_cur[CW-1:1]);
        oY    <= 8'(line_cur[LW-1:1]);
      end
    end
  end
endmodule

// File: tb/tb_bin_downscale.sv
// Directed bench for bin_downscale on a reduced 16x8 frame; expected outputs
// come from a direct 2x2 block-sum model of the pixel patterns.
module tb_bin_downscale;
  localparam int W  = 16;
  localparam int H  = 8;
  localparam int OW = W / 2;
  localparam int OH = H / 2;

  logic       iCLK = 1'b0;
  logic       iRST = 1'b0;
  logic [7:0] iDATA = '0;
  logic       iDVAL = 1'b0;
  logic       iFVAL = 1'b0;
  logic [7:0] iThreshold = '0;
  logic       oDATA, oDVAL, oFrameStart;
  logic [8:0] oX;
  logic [7:0] oY;

  logic [17:0] exp_q[$];
  logic [17:0] got_q[$];
  int fs_cnt = 0;
  int fs0, got0;
  int n_tests = 0;
  int n_fail = 0;

  bin_downscale #(.IN_W(W), .IN_H(H)) dut (
    .iCLK(iCLK), .iRST(iRST), .iDATA(iDATA), .iDVAL(iDVAL), .iFVAL(iFVAL),
    .iThreshold(iThreshold), .oDATA(oDATA), .oDVAL(oDVAL),
    .oFrameStart(oFrameStart), .oX(oX), .oY(oY)
  );

  always #5 iCLK = ~iCLK;

  always @(negedge iCLK) begin
    if (oDVAL) got_q.push_back({oDATA, oX, oY});
    if (oFrameStart) fs_cnt++;
  end

  task automatic tick();
    @(posedge iCLK);
    #1;
  endtask

  function automatic int pix(input int pat, input int x, input int y);
    if (pat == 0) return 100;
    if (pat == 1) return (x * 37 + y * 53) % 256;
    if (y < 2 && x < 2) return (x == 1 && y == 1) ? 3 : 0;
    if (y < 2 && x < 4) return 255;
    if (y < 2 && x < 6) return (x == 5 && y == 1) ? 254 : 255;
    return 0;
  endfunction

  function automatic logic exp_bit(input int pat, input int bx, input int by, input int thr);
    int s;
    s = pix(pat, 2*bx, 2*by) + pix(pat, 2*bx+1, 2*by)
      + pix(pat, 2*bx, 2*by+1) + pix(pat, 2*bx+1, 2*by+1);
`ifdef BIN_DOWNSCALE_INVERT_EN
    return s < 4 * thr;
`else
    return s >= 4 * thr;
`endif
  endfunction

  // Drops iFVAL, then streams n_lines of the pattern; thr_mid >= 0 changes
  // iThreshold from input line 4 onward. Leaves iFVAL high.
  task automatic run_frame(input int thr, input int pat, input bit gaps,
                           input bit same_start, input int n_lines, input int thr_mid);
    exp_q.delete();
    iFVAL = 1'b0; iDVAL = 1'b0;
    tick(); tick();
    iThreshold = 8'(thr);
    fs0  = fs_cnt;
    got0 = got_q.size();
    if (!same_start) begin iFVAL = 1'b1; tick(); end
    for (int y = 0; y < n_lines; y++) begin
      for (int x = 0; x < W; x++) begin
        while (gaps && $urandom_range(0, 1) == 1) begin
          iFVAL = 1'b1; iDVAL = 1'b0; iDATA = 8'($urandom_range(0, 255)); tick();
        end
        if (thr_mid >= 0 && y >= 4) iThreshold = 8'(thr_mid);
        iFVAL = 1'b1; iDVAL = 1'b1; iDATA = 8'(pix(pat, x, y));
        tick();
      end
    end
    iDVAL = 1'b0;
    tick(); tick(); tick();
    for (int by = 0; by < n_lines / 2; by++)
      for (int bx = 0; bx < OW; bx++)
        exp_q.push_back({exp_bit(pat, bx, by, thr), 9'(bx), 8'(by)});
  endtask

  task automatic test_reset();
    iRST = 1'b0; iFVAL = 1'b1; iDVAL = 1'b1; iDATA = 8'd200;
    tick(); tick();
    n_tests++; if (oDVAL !== 1'b0) begin n_fail++; $display("FAIL reset_odval: got %b expected 0", oDVAL); end
    n_tests++; if (oDATA !== 1'b0) begin n_fail++; $display("FAIL reset_odata: got %b expected 0", oDATA); end
    n_tests++; if (oFrameStart !== 1'b0) begin n_fail++; $display("FAIL reset_ofs: got %b expected 0", oFrameStart); end
    n_tests++; if ({oX, oY} !== 17'd0) begin n_fail++; $display("FAIL reset_xy: got %0d,%0d expected 0,0", oX, oY); end
    iFVAL = 1'b0; iDVAL = 1'b0;
    tick();
    iRST = 1'b1;
    tick(); tick();
  endtask

  task automatic test_frames(input string name, input int thr, input int pat,
                             input bit gaps, input bit same_start);
    run_frame(thr, pat, gaps, same_start, H, -1);
    n_tests++;
    if (got_q.size() - got0 !== OW * OH) begin
      n_fail++; $display("FAIL %s_count: got %0d expected %0d", name, got_q.size() - got0, OW * OH);
    end
    for (int i = 0; i < exp_q.size() && got0 + i < got_q.size(); i++) begin
      n_tests++;
      if (got_q[got0 + i] !== exp_q[i]) begin
        n_fail++; $display("FAIL %s[%0d]: got %h expected %h", name, i, got_q[got0 + i], exp_q[i]);
      end
    end
    n_tests++;
    if (fs_cnt - fs0 !== 1) begin n_fail++; $display("FAIL %s_fs: got %0d expected 1", name, fs_cnt - fs0); end
  endtask

  task automatic test_tail_ignored();
    got0 = got_q.size();
    for (int i = 0; i < 2 * W; i++) begin iDVAL = 1'b1; iDATA = 8'd255; tick(); end
    iDVAL = 1'b0; tick(); tick();
    n_tests++;
    if (got_q.size() !== got0) begin n_fail++; $display("FAIL tail_ignored: got %0d extra expected 0", got_q.size() - got0); end
  endtask

  task automatic test_abort();
    run_frame(60, 1, 1'b0, 1'b0, 5, -1);
    n_tests++;
    if (got_q.size() - got0 !== 2 * OW) begin n_fail++; $display("FAIL abort_partial: got %0d expected %0d", got_q.size() - got0, 2 * OW); end
    for (int i = 0; i < exp_q.size() && got0 + i < got_q.size(); i++) begin
      n_tests++;
      if (got_q[got0 + i] !== exp_q[i]) begin n_fail++; $display("FAIL abort[%0d]: got %h expected %h", i, got_q[got0 + i], exp_q[i]); end
    end
    iFVAL = 1'b0;
    got0 = got_q.size();
    for (int i = 0; i < 3 * W; i++) begin iDVAL = 1'b1; iDATA = 8'd255; tick(); end
    iDVAL = 1'b0; tick(); tick();
    n_tests++;
    if (got_q.size() !== got0) begin n_fail++; $display("FAIL abort_after_drop: got %0d expected 0", got_q.size() - got0); end
    test_frames("after_abort", 60, 1, 1'b0, 1'b0);
  endtask

  task automatic test_thr_change();
    run_frame(10, 1, 1'b0, 1'b0, H, 200);
    n_tests++;
    if (got_q.size() - got0 !== OW * OH) begin n_fail++; $display("FAIL thr_mid_count: got %0d expected %0d", got_q.size() - got0, OW * OH); end
    for (int i = 0; i < exp_q.size() && got0 + i < got_q.size(); i++) begin
      n_tests++;
      if (got_q[got0 + i] !== exp_q[i]) begin n_fail++; $display("FAIL thr_mid[%0d]: got %h expected %h", i, got_q[got0 + i], exp_q[i]); end
    end
    test_frames("thr_next", 200, 1, 1'b0, 1'b0);
  endtask

  task automatic test_reset_mid();
    run_frame(60, 1, 1'b0, 1'b0, 5, -1);
    iRST = 1'b0;
    #1;
    n_tests++;
    if ({oDATA, oDVAL, oFrameStart, oX, oY} !== 20'd0) begin
      n_fail++; $display("FAIL rst_mid_outputs: got %h expected 0", {oDATA, oDVAL, oFrameStart, oX, oY});
    end
    tick();
    iRST = 1'b1;
    got0 = got_q.size();
    fs0  = fs_cnt;
    for (int i = 0; i < W * H; i++) begin iFVAL = 1'b1; iDVAL = 1'b1; iDATA = 8'd255; tick(); end
    iDVAL = 1'b0; tick(); tick();
    n_tests++;
    if (got_q.size() !== got0 || fs_cnt !== fs0) begin
      n_fail++; $display("FAIL rst_mid_silent: got %0d outputs %0d starts expected 0 0", got_q.size() - got0, fs_cnt - fs0);
    end
    test_frames("after_rst", 60, 1, 1'b0, 1'b0);
  endtask

  initial begin
    test_reset();
    test_frames("uniform_t25", 25, 0, 1'b0, 1'b0);
    test_tail_ignored();
    test_frames("uniform_t26", 26, 0, 1'b0, 1'b0);
    test_frames("edge_t0", 0, 2, 1'b0, 1'b0);
    test_frames("edge_t1", 1, 2, 1'b0, 1'b0);
    test_frames("edge_t255", 255, 2, 1'b0, 1'b0);
    test_frames("pattern", 60, 1, 1'b0, 1'b0);
    test_frames("pattern_gaps", 60, 1, 1'b1, 1'b0);
    test_frames("same_cycle_start", 60, 1, 1'b0, 1'b1);
    test_frames("same_cycle_gaps", 90, 1, 1'b1, 1'b1);
    test_abort();
    test_thr_change();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
